// File: rtl/spectrum_peak_search_pkg.sv
// Shared constants, FSM encoding and result payload for the spectrum peak search
// and its downstream modulation classifier.
package spectrum_peak_search_pkg;

  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned NBINS         = 1 << ADDR_W;
  localparam int unsigned HALF          = NBINS / 2;
  localparam int unsigned DC_SKIP_DEF   = 2;
  localparam int unsigned GUARD_DEF     = 2;
  localparam int unsigned THR_SHIFT_DEF = 3;
  localparam int unsigned RD_LAT_DEF    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_P1   = 2'd1,
    ST_P2   = 2'd2,
    ST_DONE = 2'd3
  } sps_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] peak_idx;
    logic [DATA_W-1:0] peak_mag;
    logic [ADDR_W-1:0] sec_idx;
    logic [DATA_W-1:0] sec_mag;
    logic [ADDR_W-1:0] bin_cnt;
  } sps_result_t;

  // Unsigned, non-wrapping distance between two bin indices.
  function automatic logic [ADDR_W:0] bin_dist(input logic [ADDR_W-1:0] a,
                                               input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] ax;
    logic [ADDR_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return (ax >= bx) ? (ax - bx) : (bx - ax);
  endfunction

endpackage

// File: rtl/spectrum_peak_search_if.sv
// Magnitude RAM read port: master issues the address, slave returns data.
interface spectrum_peak_search_if;
  import spectrum_peak_search_pkg::*;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/spectrum_rd_seq.sv
// Read sequencer: sweeps DC_SKIP..HALF-1 once per start and delivers a valid flag,
// bin tag and pass-end strobe aligned with RAM data RD_LAT cycles later.
module spectrum_rd_seq
  import spectrum_peak_search_pkg::*;
#(
  parameter int unsigned DC_SKIP = DC_SKIP_DEF,
  parameter int unsigned RD_LAT  = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              vld_o,
  output logic [ADDR_W-1:0] tag_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(DC_SKIP);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(HALF - 1);

  logic              run_q;
  logic              run_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              vld_q  [RD_LAT];
  logic [ADDR_W-1:0] tag_q  [RD_LAT];
  logic              last_q [RD_LAT];

  // Address counter; holds its final value once the sweep ends.
  always_comb begin
    run_d  = run_q;
    addr_d = addr_q;
    if (start_i) begin
      run_d  = 1'b1;
      addr_d = FIRST_ADDR;
    end else if (run_q) begin
      if (addr_q == LAST_ADDR) begin
        run_d = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      addr_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      run_q     <= run_d;
      addr_q    <= addr_d;
      vld_q[0]  <= run_q;
      tag_q[0]  <= addr_q;
      last_q[0] <= run_q && (addr_q == LAST_ADDR);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign rd_addr_o = addr_q;
  assign vld_o     = vld_q[RD_LAT-1];
  assign tag_o     = tag_q[RD_LAT-1];
  assign last_o    = last_q[RD_LAT-1];

endmodule

// File: rtl/spectrum_peak_search.sv
// Two-pass peak search over the positive half of the magnitude spectrum: pass 1 finds
// the carrier, pass 2 the strongest bin outside the guard band and the occupied-bin count.
module spectrum_peak_search
  import spectrum_peak_search_pkg::*;
#(
  parameter int unsigned DC_SKIP   = DC_SKIP_DEF,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int unsigned GUARD     = GUARD_DEF,
  parameter int unsigned THR_SHIFT = THR_SHIFT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  spectrum_peak_search_if.master ram,
  output logic                   busy,
  output logic                   done,
  output logic                   result_valid,
  output logic [ADDR_W-1:0]      peak_idx,
  output logic [DATA_W-1:0]      peak_mag,
  output logic [ADDR_W-1:0]      sec_idx,
  output logic [DATA_W-1:0]      sec_mag,
  output logic [ADDR_W-1:0]      bin_cnt
);

  localparam logic [ADDR_W-1:0] FIRST_BIN  = ADDR_W'(DC_SKIP);
  localparam logic [ADDR_W:0]   GUARD_DIST = (ADDR_W+1)'(GUARD);

  sps_state_e        state_q;
  sps_state_e        state_d;
  logic              en_q;
  logic              en_arm_q;
  logic              start_c;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;
  sps_result_t       res_q, res_d;
  logic [ADDR_W-1:0] pk_idx_q, pk_idx_d;
  logic [DATA_W-1:0] pk_mag_q, pk_mag_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [ADDR_W-1:0] sc_idx_q, sc_idx_d;
  logic [DATA_W-1:0] sc_mag_q, sc_mag_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              seq_start_c;
  logic              seq_vld;
  logic              seq_last;
  logic [ADDR_W-1:0] seq_tag;
  logic [DATA_W-1:0] mag_c;

  assign mag_c = ram.rd_data;

  // A start needs en to have been seen low since reset, so a level held through reset is not an edge.
  assign start_c = en && !en_q && en_arm_q;

  spectrum_rd_seq #(
    .DC_SKIP (DC_SKIP),
    .RD_LAT  (RD_LAT)
  ) u_rd_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (seq_start_c),
    .rd_addr_o (ram.rd_addr),
    .vld_o     (seq_vld),
    .tag_o     (seq_tag),
    .last_o    (seq_last)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rv_d        = rv_q;
    res_d       = res_q;
    pk_idx_d    = pk_idx_q;
    pk_mag_d    = pk_mag_q;
    thr_d       = thr_q;
    sc_idx_d    = sc_idx_q;
    sc_mag_d    = sc_mag_q;
    cnt_d       = cnt_q;
    seq_start_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d     = ST_P1;
          busy_d      = 1'b1;
          rv_d        = 1'b0;
          seq_start_c = 1'b1;
          pk_idx_d    = '0;
          pk_mag_d    = '0;
          thr_d       = '0;
          sc_idx_d    = '0;
          sc_mag_d    = '0;
          cnt_d       = '0;
        end
      end

      ST_P1: begin
        // First searched bin always seeds the max so an all-zero spectrum reports it.
        if (seq_vld && ((seq_tag == FIRST_BIN) || (mag_c > pk_mag_q))) begin
          pk_idx_d = seq_tag;
          pk_mag_d = mag_c;
        end
        if (seq_vld && seq_last) begin
          state_d     = ST_P2;
          thr_d       = pk_mag_d >> THR_SHIFT;
          seq_start_c = 1'b1;
        end
      end

      ST_P2: begin
        if (seq_vld) begin
          if ((bin_dist(seq_tag, pk_idx_q) > GUARD_DIST) && (mag_c > sc_mag_q)) begin
            sc_idx_d = seq_tag;
            sc_mag_d = mag_c;
          end
          if ((pk_mag_q != '0) && (mag_c >= thr_q)) begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        if (seq_vld && seq_last) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rv_d    = 1'b1;
          res_d   = '{peak_idx: pk_idx_q, peak_mag: pk_mag_q,
                      sec_idx: sc_idx_d, sec_mag: sc_mag_d, bin_cnt: cnt_d};
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      en_arm_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
      res_q    <= '0;
      pk_idx_q <= '0;
      pk_mag_q <= '0;
      thr_q    <= '0;
      sc_idx_q <= '0;
      sc_mag_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en;
      en_arm_q <= en_arm_q || !en;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rv_q     <= rv_d;
      res_q    <= res_d;
      pk_idx_q <= pk_idx_d;
      pk_mag_q <= pk_mag_d;
      thr_q    <= thr_d;
      sc_idx_q <= sc_idx_d;
      sc_mag_q <= sc_mag_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = rv_q;
  assign peak_idx     = res_q.peak_idx;
  assign peak_mag     = res_q.peak_mag;
  assign sec_idx      = res_q.sec_idx;
  assign sec_mag      = res_q.sec_mag;
  assign bin_cnt      = res_q.bin_cnt;

endmodule

// File: tb/tb_spectrum_peak_search.sv
// Bench for spectrum_peak_search: RD_LAT=1 and RD_LAT=2 builds share one spectrum and en.
module tb_spectrum_peak_search;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] mem [256];
  logic [15:0] ram2_s1;
  int          checks = 0;
  int          errors = 0;

  logic        busy1, done1, rv1, busy2, done2, rv2;
  logic [7:0]  pidx1, sidx1, cnt1, pidx2, sidx2, cnt2;
  logic [15:0] pmag1, smag1, pmag2, smag2;
  logic [66:0] outs1, outs2;

  spectrum_peak_search_if ram1 ();
  spectrum_peak_search_if ram2 ();

  always #5 clk = ~clk;

  always @(posedge clk) ram1.rd_data <= mem[ram1.rd_addr];
  always @(posedge clk) begin
    ram2_s1       <= mem[ram2.rd_addr];
    ram2.rd_data  <= ram2_s1;
  end

  spectrum_peak_search #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ram(ram1),
    .busy(busy1), .done(done1), .result_valid(rv1),
    .peak_idx(pidx1), .peak_mag(pmag1), .sec_idx(sidx1), .sec_mag(smag1), .bin_cnt(cnt1));

  spectrum_peak_search #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .ram(ram2),
    .busy(busy2), .done(done2), .result_valid(rv2),
    .peak_idx(pidx2), .peak_mag(pmag2), .sec_idx(sidx2), .sec_mag(smag2), .bin_cnt(cnt2));

  assign outs1 = {busy1, done1, rv1, pidx1, pmag1, sidx1, smag1, cnt1, ram1.rd_addr};
  assign outs2 = {busy2, done2, rv2, pidx2, pmag2, sidx2, smag2, cnt2, ram2.rd_addr};

  // Reference: straight scans over the bins 2..127 using the search rules.
  task automatic model(output int pi, output int pm, output int si, output int sm, output int cnt);
    int thr;
    int d;
    pi = 2;
    pm = int'(mem[2]);
    for (int k = 3; k < 128; k++)
      if (int'(mem[k]) > pm) begin pi = k; pm = int'(mem[k]); end
    thr = pm / 8;
    si = 0; sm = 0; cnt = 0;
    for (int k = 2; k < 128; k++) begin
      d = (k > pi) ? k - pi : pi - k;
      if (d > 2 && int'(mem[k]) > sm) begin si = k; sm = int'(mem[k]); end
      if (pm != 0 && int'(mem[k]) >= thr) cnt++;
    end
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < 256; k++) mem[k] = 16'(v);
  endtask

  // Pulses en, tracks busy/result_valid/done per cycle and checks results at done.
  task automatic run_search(input string name, input bit retrig,
                            input int e_pi, input int e_pm, input int e_si,
                            input int e_sm, input int e_cnt);
    int exp_v [5];
    logic [15:0] r [5];
    string fld [5];
    int d1, d2, np1, bb1, bb2, brv;
    exp_v = '{e_pi, e_pm, e_si, e_sm, e_cnt};
    fld   = '{"peak_idx", "peak_mag", "sec_idx", "sec_mag", "bin_cnt"};
    d1 = 0; d2 = 0; np1 = 0; bb1 = 0; bb2 = 0; brv = 0;
    @(negedge clk);
    en = 1'b1;
    for (int c = 1; c <= 270; c++) begin
      @(negedge clk);
      if (busy1 !== (c <= 254)) bb1++;
      if (busy2 !== (c <= 256)) bb2++;
      if (rv1 !== (c >= 255)) brv++;
      if (done1 === 1'b1) np1++;
      if (done1 === 1'b1 && d1 == 0) begin
        d1 = c;
        r = '{16'(pidx1), pmag1, 16'(sidx1), smag1, 16'(cnt1)};
        for (int f = 0; f < 5; f++) begin
          checks++;
          if (r[f] !== 16'(exp_v[f])) begin
            errors++;
            $display("FAIL %s dut1 %s: got %0d expected %0d", name, fld[f], r[f], exp_v[f]);
          end
        end
      end
      if (done2 === 1'b1 && d2 == 0) begin
        d2 = c;
        r = '{16'(pidx2), pmag2, 16'(sidx2), smag2, 16'(cnt2)};
        for (int f = 0; f < 5; f++) begin
          checks++;
          if (r[f] !== 16'(exp_v[f])) begin
            errors++;
            $display("FAIL %s dut2 %s: got %0d expected %0d", name, fld[f], r[f], exp_v[f]);
          end
        end
      end
      if (c == 270) begin
        r = '{16'(pidx1), pmag1, 16'(sidx1), smag1, 16'(cnt1)};
        for (int f = 0; f < 5; f++) begin
          checks++;
          if (r[f] !== 16'(exp_v[f])) begin
            errors++;
            $display("FAIL %s dut1 %s held: got %0d expected %0d", name, fld[f], r[f], exp_v[f]);
          end
        end
      end
      if (retrig && c == 90) en = 1'b0;
      if (retrig && c == 100) en = 1'b1;
    end
    en = 1'b0;
    checks++;
    if (d1 !== 255) begin errors++; $display("FAIL %s dut1 done_cycle: got %0d expected 255", name, d1); end
    checks++;
    if (d2 !== 257) begin errors++; $display("FAIL %s dut2 done_cycle: got %0d expected 257", name, d2); end
    checks++;
    if (np1 !== 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, np1); end
    checks++;
    if (bb1 !== 0) begin errors++; $display("FAIL %s dut1 busy_window: got %0d bad cycles expected 0", name, bb1); end
    checks++;
    if (bb2 !== 0) begin errors++; $display("FAIL %s dut2 busy_window: got %0d bad cycles expected 0", name, bb2); end
    checks++;
    if (brv !== 0) begin errors++; $display("FAIL %s result_valid_window: got %0d bad cycles expected 0", name, brv); end
  endtask

  task automatic test_reset();
    fill(0);
    repeat (3) @(negedge clk);
    checks++;
    if (outs1 !== '0) begin errors++; $display("FAIL reset dut1 outputs: got %h expected 0", outs1); end
    checks++;
    if (outs2 !== '0) begin errors++; $display("FAIL reset dut2 outputs: got %h expected 0", outs2); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs1 !== '0) begin errors++; $display("FAIL reset idle dut1 outputs: got %h expected 0", outs1); end
  endtask

  task automatic test_single_tone();
    fill(10);
    mem[40] = 16'd5000;
    run_search("single_tone", 1'b0, 40, 5000, 2, 10, 1);
  endtask

  task automatic test_am_sidebands();
    fill(0);
    mem[64] = 16'd8000; mem[60] = 16'd2000; mem[68] = 16'd2000;
    run_search("am_sidebands", 1'b0, 64, 8000, 60, 2000, 3);
  endtask

  task automatic test_guard_dc();
    fill(0);
    mem[0] = 16'd65535; mem[1] = 16'd60000; mem[30] = 16'd9000;
    mem[31] = 16'd8500; mem[50] = 16'd3000;
    run_search("guard_dc", 1'b0, 30, 9000, 50, 3000, 3);
  endtask

  task automatic test_empty();
    fill(0);
    run_search("empty", 1'b0, 2, 0, 0, 0, 0);
  endtask

  task automatic test_last_bin();
    fill(0);
    mem[127] = 16'd4000;
    mem[200] = 16'd60000;
    run_search("last_bin", 1'b0, 127, 4000, 0, 0, 1);
  endtask

  task automatic test_retrigger();
    int pi, pm, si, sm, cnt;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom_range(0, 65535));
    model(pi, pm, si, sm, cnt);
    run_search("retrigger", 1'b1, pi, pm, si, sm, cnt);
  endtask

  task automatic test_random();
    int pi, pm, si, sm, cnt;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 256; k++)
        mem[k] = (it % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 3) * 1000);
      if (it == 2) mem[2] = 16'hffff;
      if (it == 4) mem[$urandom_range(2, 127)] = 16'hffff;
      model(pi, pm, si, sm, cnt);
      run_search($sformatf("random%0d", it), 1'b0, pi, pm, si, sm, cnt);
    end
  endtask

  task automatic test_abort();
    int pi, pm, si, sm, cnt, bad;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom_range(0, 40000));
    @(negedge clk);
    en = 1'b1;
    repeat (80) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs1 !== '0) begin errors++; $display("FAIL abort dut1 outputs: got %h expected 0", outs1); end
    checks++;
    if (outs2 !== '0) begin errors++; $display("FAIL abort dut2 outputs: got %h expected 0", outs2); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy1 !== 1'b0 || busy2 !== 1'b0 || ram1.rd_addr !== 8'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort held_en_no_start: got %0d bad cycles expected 0", bad); end
    en = 1'b0;
    model(pi, pm, si, sm, cnt);
    run_search("abort_restart", 1'b0, pi, pm, si, sm, cnt);
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_am_sidebands();
    test_guard_dc();
    test_empty();
    test_last_bin();
    test_retrigger();
    test_random();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
